dat_write_status: RTL

DAT_WRITE_STATUS -- requirements
Module: dat_write_status

---
 rtl/dat_write_status.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dat_write_status.sv
// dat_write_status
//   Tracks the card's response after a write data block has been sent. It
//   collects the CRC status token (start bit, 3-bit token, end bit) from DAT0,
//   then waits out the busy phase. DAT0 low means the card is busy, and a
//   bounded counter turns a stuck-busy card into a timeout.
//
// Parameters
//   StartWindow    max SD clock strobes to wait for the CRC status start bit
//   TimeoutBase    busy timeout exponent base
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   sd_clk_en_p_i  SD clock rising-edge strobe; DAT0 is only sampled on it
//   dat0_i         DAT0 line from the card
//   start_i        one-cycle pulse after the write block end bit is driven
//   abort_i        software DAT reset; aborts any operation
//   timeout_bits_i data timeout counter value field (sampled at start_i)
//   busy_o         status or busy phase in progress
//   done_o         one-cycle completion pulse
//   crc_err_o, write_err_o, token_err_o, end_bit_err_o, timeout_o
//                  result flags; valid while done_o=1 and held until next start
module dat_write_status #(
  parameter int StartWindow = 16,
  parameter int TimeoutBase = 13
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sd_clk_en_p_i,
  input  logic       dat0_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] timeout_bits_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       crc_err_o,
  output logic       write_err_o,
  output logic       token_err_o,
  output logic       end_bit_err_o,
  output logic       timeout_o
);

  localparam int WinW = (StartWindow < 2) ? 1 : $clog2(StartWindow);
  localparam logic [WinW-1:0] WinLast = WinW'(StartWindow - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    TOKEN,
    END_BIT,
    BUSY,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [WinW-1:0] win_cnt_q, win_cnt_d;
  logic [1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      token_q, token_d;
  logic [27:0]     busy_cnt_q, busy_cnt_d;
  logic [3:0]      tbits_q, tbits_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            crc_err_q, crc_err_d;
  logic            write_err_q, write_err_d;
  logic            token_err_q, token_err_d;
  logic            end_bit_err_q, end_bit_err_d;
  logic            timeout_q, timeout_d;

  logic [2:0]      token_shift;
  logic [27:0]     busy_cnt_inc;
  logic [27:0]     busy_limit;

  // Busy timeout fires when the count reaches 2^(TimeoutBase+N)-1.
  always_comb begin
    busy_limit = (28'd1 << (5'(TimeoutBase) + {1'b0, tbits_q})) - 28'd1;
  end

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    token_d       = token_q;
    busy_cnt_d    = busy_cnt_q;
    tbits_d       = tbits_q;
    crc_err_d     = crc_err_q;
    write_err_d   = write_err_q;
    token_err_d   = token_err_q;
    end_bit_err_d = end_bit_err_q;
    timeout_d     = timeout_q;
    token_shift   = {token_q[1:0], dat0_i};
    busy_cnt_inc  = busy_cnt_q + 28'd1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d       = WAIT_START;
          win_cnt_d     = '0;
          bit_cnt_d     = '0;
          token_d       = '0;
          busy_cnt_d    = '0;
          // Field value 15 is reserved; treat it as the largest legal one.
          tbits_d       = (timeout_bits_i == 4'hF) ? 4'hE : timeout_bits_i;
          crc_err_d     = 1'b0;
          write_err_d   = 1'b0;
          token_err_d   = 1'b0;
          end_bit_err_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      WAIT_START: begin
        if (sd_clk_en_p_i) begin
          if (!dat0_i) begin
            state_d   = TOKEN;
            bit_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WinW'(1);
            if (win_cnt_q == WinLast) begin
              token_err_d = 1'b1;
              state_d     = DONE;
            end
          end
        end
      end
      TOKEN: begin
        if (sd_clk_en_p_i) begin
          token_d   = token_shift;
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd2) begin
            state_d = END_BIT;
            case (token_shift)
              3'b010:  ;
              3'b101:  crc_err_d   = 1'b1;
              3'b110:  write_err_d = 1'b1;
              default: token_err_d = 1'b1;
            endcase
          end
        end
      end
      END_BIT: begin
        if (sd_clk_en_p_i) begin
          if (!dat0_i) end_bit_err_d = 1'b1;
          state_d    = BUSY;
          busy_cnt_d = '0;
        end
      end
      BUSY: begin
        if (sd_clk_en_p_i) begin
          if (dat0_i) begin
            state_d = DONE;
          end else begin
            busy_cnt_d = busy_cnt_inc;
            if (busy_cnt_inc == busy_limit) begin
              timeout_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort_i) begin
      state_d       = IDLE;
      crc_err_d     = 1'b0;
      write_err_d   = 1'b0;
      token_err_d   = 1'b0;
      end_bit_err_d = 1'b0;
      timeout_d     = 1'b0;
    end

    // Status outputs are registered versions of the next state.
    busy_d = (state_d == WAIT_START) || (state_d == TOKEN) ||
             (state_d == END_BIT) || (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      token_q       <= '0;
      busy_cnt_q    <= '0;
      tbits_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      write_err_q   <= 1'b0;
      token_err_q   <= 1'b0;
      end_bit_err_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      token_q       <= token_d;
      busy_cnt_q    <= busy_cnt_d;
      tbits_q       <= tbits_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      crc_err_q     <= crc_err_d;
      write_err_q   <= write_err_d;
      token_err_q   <= token_err_d;
      end_bit_err_q <= end_bit_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign crc_err_o     = crc_err_q;
  assign write_err_o   = write_err_q;
  assign token_err_o   = token_err_q;
  assign end_bit_err_o = end_bit_err_q;
  assign timeout_o     = timeout_q;

endmodule
